// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-side decode/hazard signal bundle between decoder and hazard scoreboard
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 4,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 16
);
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic                  has_src1;
  logic                  has_src2;
  logic [REG_ADDR_W-1:0] dst;
  logic                  wb_en;
  logic                  mem_read;
  logic                  flush;
  logic                  freeze;
  logic                  stall;
  logic [SEL_W-1:0]      fwd_sel1;
  logic [SEL_W-1:0]      fwd_sel2;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output issue_valid, src1, src2, has_src1, has_src2, dst, wb_en, mem_read, flush, freeze,
    input  stall, fwd_sel1, fwd_sel2, stall_cnt
  );

  modport slave (
    input  issue_valid, src1, src2, has_src1, has_src2, dst, wb_en, mem_read, flush, freeze,
    output stall, fwd_sel1, fwd_sel2, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - In-flight destination scoreboard driving stall, forwarding selects and a stall counter
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 4,
  parameter int STAGES     = 3,
  parameter bit FWD_EN     = 1'b1,
  parameter int SEL_W      = $clog2(STAGES + 1),
  parameter int CNT_W      = 16
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave hz
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dst;
    logic                  wb_en;
    logic                  mem_read;
  } slot_t;

  // slots[1] is EXE, slots[STAGES] is WB
  slot_t            slots [1:STAGES];
  logic [STAGES:1]  match1;
  logic [STAGES:1]  match2;
  logic [SEL_W-1:0] young1;
  logic [SEL_W-1:0] young2;
  logic             raw_hit;
  logic             load_use;
  logic             stall_int;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int k = 1; k <= STAGES; k++) begin
      match1[k] = hz.has_src1 && hz.issue_valid && slots[k].valid && slots[k].wb_en
                  && (slots[k].dst == hz.src1);
      match2[k] = hz.has_src2 && hz.issue_valid && slots[k].valid && slots[k].wb_en
                  && (slots[k].dst == hz.src2);
    end
  end

  // Scan oldest to youngest so the lowest matching slot overwrites older ones
  always_comb begin
    young1 = '0;
    young2 = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (match1[k]) young1 = SEL_W'(k);
      if (match2[k]) young2 = SEL_W'(k);
    end
  end

  always_comb begin
    raw_hit   = (|match1) || (|match2);
    load_use  = slots[1].mem_read && ((young1 == SEL_W'(1)) || (young2 == SEL_W'(1)));
    stall_int = (FWD_EN ? load_use : raw_hit) && !hz.flush;
  end

  assign hz.stall     = stall_int;
  assign hz.fwd_sel1  = FWD_EN ? young1 : '0;
  assign hz.fwd_sel2  = FWD_EN ? young2 : '0;
  assign hz.stall_cnt = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= STAGES; k++) slots[k] <= '0;
      cnt <= '0;
    end else if (!hz.freeze) begin
      for (int k = STAGES; k >= 2; k--) slots[k] <= slots[k-1];
      if (hz.issue_valid && !stall_int && !hz.flush)
        slots[1] <= '{valid: 1'b1, dst: hz.dst, wb_en: hz.wb_en, mem_read: hz.mem_read};
      else
        slots[1] <= '0;
      if (stall_int && (cnt != '1)) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - Directed and random checks of hazard_scoreboard against a queue-based reference
module tb_hazard_scoreboard;
  localparam int STAGES = 3;
  localparam int CNT_MAX = 65535;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_ADDR_W(4), .SEL_W(2), .CNT_W(16)) hz_f ();
  hazard_scoreboard_if #(.REG_ADDR_W(4), .SEL_W(2), .CNT_W(16)) hz_s ();

  hazard_scoreboard #(.REG_ADDR_W(4), .STAGES(STAGES), .FWD_EN(1'b1), .SEL_W(2), .CNT_W(16))
    dut_f (.clk(clk), .rst(rst), .hz(hz_f));
  hazard_scoreboard #(.REG_ADDR_W(4), .STAGES(STAGES), .FWD_EN(1'b0), .SEL_W(2), .CNT_W(16))
    dut_s (.clk(clk), .rst(rst), .hz(hz_s));

  typedef struct {
    bit v;
    int d;
    bit w;
    bit m;
  } ent_t;

  // Index 0 is the youngest in-flight instruction
  ent_t pipe_f[$];
  ent_t pipe_s[$];
  int   cnt_f;
  int   cnt_s;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ent_t b;
    b = '{1'b0, 0, 1'b0, 1'b0};
    pipe_f = {};
    pipe_s = {};
    for (int i = 0; i < STAGES; i++) begin
      pipe_f.push_back(b);
      pipe_s.push_back(b);
    end
    cnt_f = 0;
    cnt_s = 0;
  endtask

  function automatic int youngest(input bit which, input bit iv, input bit h, input int s);
    ent_t p[$];
    int   r;
    p = which ? pipe_s : pipe_f;
    r = 0;
    if (iv && h)
      for (int i = p.size() - 1; i >= 0; i--)
        if (p[i].v && p[i].w && (p[i].d == s)) r = i + 1;
    return r;
  endfunction

  task automatic model_eval(input bit which, input bit iv, input int s1, input int s2,
                            input bit h1, input bit h2, input bit fl,
                            output bit st, output int sel1, output int sel2);
    int  y1, y2;
    bit  slot1_load;
    y1 = youngest(which, iv, h1, s1);
    y2 = youngest(which, iv, h2, s2);
    slot1_load = which ? pipe_s[0].m : pipe_f[0].m;
    if (which) begin
      st   = (y1 != 0) || (y2 != 0);
      sel1 = 0;
      sel2 = 0;
    end else begin
      st   = slot1_load && ((y1 == 1) || (y2 == 1));
      sel1 = y1;
      sel2 = y2;
    end
    if (fl) st = 1'b0;
  endtask

  task automatic model_clock(input bit which, input bit iv, input int d, input bit wb, input bit mr,
                             input bit fl, input bit fz, input bit st);
    ent_t e;
    if (fz) return;
    e = (iv && !st && !fl) ? '{1'b1, d, wb, mr} : '{1'b0, 0, 1'b0, 1'b0};
    if (which) begin
      pipe_s.push_front(e);
      void'(pipe_s.pop_back());
      if (st && cnt_s < CNT_MAX) cnt_s++;
    end else begin
      pipe_f.push_front(e);
      void'(pipe_f.pop_back());
      if (st && cnt_f < CNT_MAX) cnt_f++;
    end
  endtask

  task automatic drive(input bit which, input bit iv, input int d, input int s1, input int s2,
                       input bit h1, input bit h2, input bit wb, input bit mr,
                       input bit fl, input bit fz);
    if (which) begin
      hz_s.issue_valid = iv; hz_s.dst = d[3:0]; hz_s.src1 = s1[3:0]; hz_s.src2 = s2[3:0];
      hz_s.has_src1 = h1; hz_s.has_src2 = h2; hz_s.wb_en = wb; hz_s.mem_read = mr;
      hz_s.flush = fl; hz_s.freeze = fz;
    end else begin
      hz_f.issue_valid = iv; hz_f.dst = d[3:0]; hz_f.src1 = s1[3:0]; hz_f.src2 = s2[3:0];
      hz_f.has_src1 = h1; hz_f.has_src2 = h2; hz_f.wb_en = wb; hz_f.mem_read = mr;
      hz_f.flush = fl; hz_f.freeze = fz;
    end
  endtask

  task automatic idle(input bit which);
    drive(which, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called at the falling edge with inputs already driven; returns at the next falling edge
  task automatic step();
    bit st_f, st_s;
    int e1, e2;
    #1;
    model_eval(1'b0, hz_f.issue_valid, int'(hz_f.src1), int'(hz_f.src2), hz_f.has_src1,
               hz_f.has_src2, hz_f.flush, st_f, e1, e2);
    chk("f_stall", {31'b0, hz_f.stall}, {31'b0, st_f});
    if (!st_f) begin
      chk("f_sel1", {30'b0, hz_f.fwd_sel1}, e1);
      chk("f_sel2", {30'b0, hz_f.fwd_sel2}, e2);
    end
    model_eval(1'b1, hz_s.issue_valid, int'(hz_s.src1), int'(hz_s.src2), hz_s.has_src1,
               hz_s.has_src2, hz_s.flush, st_s, e1, e2);
    chk("s_stall", {31'b0, hz_s.stall}, {31'b0, st_s});
    chk("s_sel1", {30'b0, hz_s.fwd_sel1}, 0);
    chk("s_sel2", {30'b0, hz_s.fwd_sel2}, 0);
    @(posedge clk);
    model_clock(1'b0, hz_f.issue_valid, int'(hz_f.dst), hz_f.wb_en, hz_f.mem_read,
                hz_f.flush, hz_f.freeze, st_f);
    model_clock(1'b1, hz_s.issue_valid, int'(hz_s.dst), hz_s.wb_en, hz_s.mem_read,
                hz_s.flush, hz_s.freeze, st_s);
    @(negedge clk);
    chk("f_cnt", {16'b0, hz_f.stall_cnt}, cnt_f);
    chk("s_cnt", {16'b0, hz_s.stall_cnt}, cnt_s);
  endtask

  task automatic drain();
    idle(1'b0);
    idle(1'b1);
    repeat (STAGES) step();
  endtask

  initial begin
    int c0;
    // Reset with every input high
    drive(1'b0, 1'b1, 15, 15, 15, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 15, 15, 15, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_f_stall", {31'b0, hz_f.stall}, 0);
    chk("rst_f_sel1", {30'b0, hz_f.fwd_sel1}, 0);
    chk("rst_f_sel2", {30'b0, hz_f.fwd_sel2}, 0);
    chk("rst_f_cnt", {16'b0, hz_f.stall_cnt}, 0);
    chk("rst_s_stall", {31'b0, hz_s.stall}, 0);
    chk("rst_s_cnt", {16'b0, hz_s.stall_cnt}, 0);
    rst = 1'b0;
    model_reset();
    idle(1'b0);
    idle(1'b1);
    // First issue after reset sees no matches
    drive(1'b0, 1'b1, 3, 15, 15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("post_rst_sel1", {30'b0, hz_f.fwd_sel1}, 0);
    step();
    drain();

    // ADD r3 then SUB r4,r3,r3 with 0..3 NOPs between
    for (int g = 0; g <= 3; g++) begin
      drive(1'b0, 1'b1, 3, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      idle(1'b0);
      repeat (g) step();
      drive(1'b0, 1'b1, 4, 3, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      chk("gap_stall", {31'b0, hz_f.stall}, 0);
      chk("gap_sel1", {30'b0, hz_f.fwd_sel1}, (g < 3) ? g + 1 : 0);
      chk("gap_sel2", {30'b0, hz_f.fwd_sel2}, (g < 3) ? g + 1 : 0);
      step();
      drain();
    end

    // Load-use: LDR r2 then ADD r5,r2,r1
    drive(1'b0, 1'b1, 2, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, 5, 2, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lu_stall", {31'b0, hz_f.stall}, 1);
    step();
    #1;
    chk("lu_stall_done", {31'b0, hz_f.stall}, 0);
    chk("lu_sel1", {30'b0, hz_f.fwd_sel1}, 2);
    chk("lu_cnt", {16'b0, hz_f.stall_cnt}, 1);
    step();
    drain();

    // Youngest producer wins
    drive(1'b0, 1'b1, 6, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    drive(1'b0, 1'b1, 8, 6, 6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("young_sel1", {30'b0, hz_f.fwd_sel1}, 1);
    step();
    drain();

    // No forwarding: reader of r7 waits STAGES cycles
    drive(1'b1, 1'b1, 7, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    c0 = int'(hz_s.stall_cnt);
    drive(1'b1, 1'b1, 8, 7, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < STAGES; i++) begin
      #1;
      chk("nofwd_stall", {31'b0, hz_s.stall}, 1);
      step();
    end
    #1;
    chk("nofwd_release", {31'b0, hz_s.stall}, 0);
    chk("nofwd_sel1", {30'b0, hz_s.fwd_sel1}, 0);
    chk("nofwd_cnt", {16'b0, hz_s.stall_cnt}, c0 + STAGES);
    step();
    drain();

    // Flush during a load-use stall
    drive(1'b0, 1'b1, 2, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    c0 = int'(hz_f.stall_cnt);
    drive(1'b0, 1'b1, 5, 2, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    chk("flush_stall", {31'b0, hz_f.stall}, 0);
    step();
    chk("flush_cnt", {16'b0, hz_f.stall_cnt}, c0);
    drive(1'b0, 1'b1, 5, 2, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("flush_bubble_stall", {31'b0, hz_f.stall}, 0);
    chk("flush_bubble_sel1", {30'b0, hz_f.fwd_sel1}, 2);
    step();
    drain();

    // Freeze for 5 cycles during a load-use stall
    drive(1'b0, 1'b1, 2, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    c0 = int'(hz_f.stall_cnt);
    drive(1'b0, 1'b1, 5, 2, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (5) begin
      #1;
      chk("frz_stall", {31'b0, hz_f.stall}, 1);
      step();
    end
    chk("frz_cnt", {16'b0, hz_f.stall_cnt}, c0);
    drive(1'b0, 1'b1, 5, 2, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("frz_release_stall", {31'b0, hz_f.stall}, 1);
    step();
    chk("frz_release_cnt", {16'b0, hz_f.stall_cnt}, c0 + 1);
    #1;
    chk("frz_fwd_sel1", {30'b0, hz_f.fwd_sel1}, 2);
    step();
    drain();

    // Reset asserted mid-stall
    drive(1'b0, 1'b1, 2, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, 5, 2, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("pre_rst_stall", {31'b0, hz_f.stall}, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_stall", {31'b0, hz_f.stall}, 0);
    chk("async_rst_cnt", {16'b0, hz_f.stall_cnt}, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("post_rst_stall", {31'b0, hz_f.stall}, 0);
    chk("post_rst_sel", {30'b0, hz_f.fwd_sel1}, 0);
    step();
    drain();

    // Random traffic on both configurations
    for (int n = 0; n < 400; n++) begin
      for (int w = 0; w < 2; w++)
        drive(w[0], $urandom_range(3) != 0, $urandom_range(3), $urandom_range(3), $urandom_range(3),
              $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom_range(3) != 0,
              $urandom_range(2) == 0, $urandom_range(9) == 0, $urandom_range(9) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
